// File: rtl/spi_slave_rx_tx.sv
// SPI responder. SCK/SS/MOSI are oversampled in the CLOCK domain; all four
// CPOL/CPHA modes, MSB first, with a one-word TX holding buffer.
module spi_slave_rx_tx #(
  parameter int                D_PACK = 8,
  parameter logic [D_PACK-1:0] FILL   = {D_PACK{1'b1}}
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic              C_POL,
  input  logic              C_PH,
  input  logic [D_PACK-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [D_PACK-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              UNDERRUN,
  output logic              BUSY
);

  localparam int CW = $clog2(D_PACK + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_sync_q, sck_sync_d;
  logic [2:0]        ss_sync_q, ss_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic              sample_q, sample_d;
  logic              shift_q, shift_d;
  logic              ss_fall_q, ss_fall_d;
  logic              ss_rise_q, ss_rise_d;
  logic              mosi_smp_q, mosi_smp_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [D_PACK-1:0] rx_sr_q, rx_sr_d;
  logic [D_PACK-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic [D_PACK-1:0] tx_sr_q, tx_sr_d;
  logic [D_PACK-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              sck_edge;
  logic              lead_edge;
  logic              trail_edge;
  logic              load;

  // Synchronizer chains and edge strobes; strobes are registered together
  // with the MOSI bit so a sample always pairs with the data seen at its edge.
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], SCK};
    ss_sync_d   = {ss_sync_q[1:0], SS};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
    sck_edge    = sck_sync_q[1] ^ sck_sync_q[2];
    lead_edge   = sck_edge & (sck_sync_q[1] != C_POL);
    trail_edge  = sck_edge & (sck_sync_q[1] == C_POL);
    sample_d    = C_PH ? trail_edge : lead_edge;
    shift_d     = C_PH ? lead_edge : trail_edge;
    ss_fall_d   = ss_sync_q[2] & ~ss_sync_q[1];
    ss_rise_d   = ~ss_sync_q[2] & ss_sync_q[1];
    mosi_smp_d  = mosi_sync_q[1];
  end

  // Synchronizer flops carry no reset so a reset mid-frame cannot fake an SS edge.
  always_ff @(posedge CLOCK) begin
    sck_sync_q  <= sck_sync_d;
    ss_sync_q   <= ss_sync_d;
    mosi_sync_q <= mosi_sync_d;
  end

  // Frame FSM, shift registers, word counter and TX holding buffer.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    tx_sr_d    = tx_sr_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall_q) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load      = ~C_PH;
        end
      end
      ACTIVE: begin
        if (ss_rise_q) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          if (sample_q) begin
            rx_sr_d = {rx_sr_q[D_PACK-2:0], mosi_smp_q};
            if (bit_cnt_q == CW'(D_PACK - 1)) begin
              rx_data_d  = rx_sr_d;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          // A shift edge at bit_cnt==0 is either the edge after a finished word
          // (CPHA=0) or the launch edge of bit 0 (CPHA=1): both load a new word.
          if (shift_q) begin
            if (bit_cnt_q == '0) load = 1'b1;
            else                 tx_sr_d = tx_sr_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (buf_full_q) begin
        tx_sr_d    = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_sr_d    = FILL;
        underrun_d = 1'b1;
      end
    end

    // Write is evaluated after the load so a coincident load sees the old buffer.
    if (TX_VALID && !buf_full_q) begin
      buf_d      = TX_DATA;
      buf_full_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q    <= IDLE;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      ss_fall_q  <= 1'b0;
      ss_rise_q  <= 1'b0;
      mosi_smp_q <= 1'b0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      tx_sr_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      ss_fall_q  <= ss_fall_d;
      ss_rise_q  <= ss_rise_d;
      mosi_smp_q <= mosi_smp_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      tx_sr_q    <= tx_sr_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  assign BUSY     = (state_q == ACTIVE);
  assign MISO_OE  = BUSY;
  assign MISO     = BUSY ? tx_sr_q[D_PACK-1] : 1'b1;
  assign TX_READY = ~buf_full_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign UNDERRUN = underrun_q;

endmodule
